// File: rtl/fadd_scheduler.sv
// rtl/fadd_scheduler.sv - two-requester round-robin scheduler sharing one FP add back end

// Pre-adder front end: orders operands by magnitude, aligns the smaller mantissa
// and resolves NaN/Inf/zero operands without needing the back end.
module preadder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [27:0] o_mantis_great,
  output logic [27:0] o_mantis_small,
  output logic        o_special_case,
  output logic [31:0] o_special_result
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        w_swap;
  logic [31:0] w_great;
  logic [31:0] w_small;
  logic [7:0]  w_diff;
  logic [27:0] w_m_small;
  logic [27:0] w_shifted;
  logic [27:0] w_lost_mask;
  logic        w_sticky;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  // Equal magnitudes keep operand a as the great one.
  assign w_swap    = i_b[30:0] > i_a[30:0];
  assign w_great   = w_swap ? i_b : i_a;
  assign w_small   = w_swap ? i_a : i_b;
  assign w_diff    = w_great[30:23] - w_small[30:23];

  // Mantissa layout: [27] carry headroom, [26] hidden one, [25:3] fraction, [2:0] guard/round/sticky.
  assign w_m_small   = {2'b01, w_small[22:0], 3'b000};
  assign w_shifted   = w_m_small >> w_diff;
  assign w_lost_mask = (28'd1 << w_diff) - 28'd1;
  assign w_sticky    = |(w_m_small & w_lost_mask);

  assign o_sign         = w_great[31];
  assign o_exp          = w_great[30:23];
  assign o_mantis_great = {2'b01, w_great[22:0], 3'b000};
  // Shifts of 28 or more leave only the sticky bit.
  assign o_mantis_small = (w_diff >= 8'd28) ? 28'd1 : (w_shifted | {27'd0, w_sticky});

  // Exponent 0 is treated as zero (denormals flushed).
  assign w_a_nan  = (&i_a[30:23]) && (|i_a[22:0]);
  assign w_b_nan  = (&i_b[30:23]) && (|i_b[22:0]);
  assign w_a_inf  = (&i_a[30:23]) && !(|i_a[22:0]);
  assign w_b_inf  = (&i_b[30:23]) && !(|i_b[22:0]);
  assign w_a_zero = !(|i_a[30:23]);
  assign w_b_zero = !(|i_b[30:23]);

  // Special-case priority: NaN, infinities, zeros.
  always_comb begin
    o_special_case   = 1'b1;
    o_special_result = '0;
    if (w_a_nan || w_b_nan)      o_special_result = QNAN;
    else if (w_a_inf && w_b_inf) o_special_result = (i_a[31] != i_b[31]) ? QNAN : i_a;
    else if (w_a_inf)            o_special_result = i_a;
    else if (w_b_inf)            o_special_result = i_b;
    else if (w_a_zero && w_b_zero) o_special_result = {i_a[31] & i_b[31], 31'd0};
    else if (w_a_zero)           o_special_result = i_b;
    else if (w_b_zero)           o_special_result = i_a;
    else                         o_special_case   = 1'b0;
  end
endmodule

module fadd_scheduler #(
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data0,
  output logic [31:0]      rsp_data1,
  output logic             dp_valid,
  output logic             dp_sign,
  output logic [7:0]       dp_exp,
  output logic [27:0]      dp_mantis_great,
  output logic [27:0]      dp_mantis_small,
  input  logic [31:0]      dp_result,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] special_cnt
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state [2];
  logic [31:0]      r_data  [2];
  logic             r_ptr;
  logic [LAT-1:0]   r_trk_v;
  logic [LAT-1:0]   r_trk_tag;
  logic [CNT_W-1:0] r_ops;
  logic [CNT_W-1:0] r_spc;

  logic [1:0]  w_elig;
  logic [1:0]  w_gnt;
  logic [1:0]  w_hs;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic        w_special;
  logic [31:0] w_spres;
  logic        w_cap_v;
  logic        w_cap_tag;

  assign w_elig[0] = req_valid[0] && (r_state[0] == S_IDLE);
  assign w_elig[1] = req_valid[1] && (r_state[1] == S_IDLE);

  // Grants are held off while reset is asserted so req_ready shows its reset value.
  assign w_gnt[0] = rst_n && w_elig[0] && (!w_elig[1] || !r_ptr);
  assign w_gnt[1] = rst_n && w_elig[1] && (!w_elig[0] ||  r_ptr);
  assign req_ready = w_gnt;

  assign w_op_a = w_gnt[1] ? req_a1 : req_a0;
  assign w_op_b = w_gnt[1] ? req_b1 : req_b0;

  preadder u_preadder (
    .i_a              (w_op_a),
    .i_b              (w_op_b),
    .o_sign           (dp_sign),
    .o_exp            (dp_exp),
    .o_mantis_great   (dp_mantis_great),
    .o_mantis_small   (dp_mantis_small),
    .o_special_case   (w_special),
    .o_special_result (w_spres)
  );

  assign dp_valid  = (|w_gnt) && !w_special;
  assign w_cap_v   = r_trk_v[LAT-1];
  assign w_cap_tag = r_trk_tag[LAT-1];

  assign rsp_valid[0] = (r_state[0] == S_DONE);
  assign rsp_valid[1] = (r_state[1] == S_DONE);
  assign rsp_data0    = r_data[0];
  assign rsp_data1    = r_data[1];
  assign w_hs         = rsp_valid & rsp_ready;

  assign ops_done    = r_ops;
  assign special_cnt = r_spc;

  // Per-requester FSMs; a special result skips straight to DONE so it is visible one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= S_IDLE;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_gnt[i]) begin
              if (w_special) begin
                r_state[i] <= S_DONE;
                r_data[i]  <= w_spres;
              end else begin
                r_state[i] <= S_BUSY;
              end
            end
          end
          S_BUSY: begin
            if (w_cap_v && (w_cap_tag == 1'(i))) begin
              r_state[i] <= S_DONE;
              r_data[i]  <= dp_result;
            end
          end
          S_DONE: begin
            if (rsp_ready[i]) r_state[i] <= S_IDLE;
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // In-flight tracker: {valid, tag} delayed LAT cycles to line up with dp_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_v   <= '0;
      r_trk_tag <= '0;
    end else begin
      r_trk_v[0]   <= dp_valid;
      r_trk_tag[0] <= w_gnt[1];
      for (int k = 1; k < LAT; k++) begin
        r_trk_v[k]   <= r_trk_v[k-1];
        r_trk_tag[k] <= r_trk_tag[k-1];
      end
    end
  end

  // Round-robin pointer and wrapping statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
      r_ops <= '0;
      r_spc <= '0;
    end else begin
      if (|w_gnt) r_ptr <= w_gnt[0];
      r_ops <= r_ops + CNT_W'(w_hs[0]) + CNT_W'(w_hs[1]);
      if ((|w_gnt) && w_special) r_spc <= r_spc + 1'b1;
    end
  end
endmodule

// File: tb/tb_fadd_scheduler.sv
// tb/tb_fadd_scheduler.sv - randomized self-checking bench for fadd_scheduler
module tb_fadd_scheduler;
  localparam int LAT   = 3;
  localparam int CNT_W = 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0]      req_a0, req_b0, req_a1, req_b1, rsp_data0, rsp_data1, dp_result;
  logic             dp_valid, dp_sign;
  logic [7:0]       dp_exp;
  logic [27:0]      dp_mantis_great, dp_mantis_small;
  logic [CNT_W-1:0] ops_done, special_cnt;

  fadd_scheduler #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .dp_valid(dp_valid), .dp_sign(dp_sign), .dp_exp(dp_exp),
    .dp_mantis_great(dp_mantis_great), .dp_mantis_small(dp_mantis_small),
    .dp_result(dp_result), .ops_done(ops_done), .special_cnt(special_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: outstanding op per requester, when its answer is due, and its value.
  bit          m_has [2];
  int          m_due [2];
  logic [31:0] m_val [2];
  bit          m_ptr;
  int          m_ops, m_spc;
  int          c;
  logic [31:0] res_at [int];

  function automatic void ref_pre(input logic [31:0] a, input logic [31:0] b,
                                  output bit sp, output logic [31:0] r, output bit sg,
                                  output logic [7:0] e, output logic [27:0] mg,
                                  output logic [27:0] ms);
    bit an, bn, ai, bi, az, bz;
    logic [31:0] big, sml;
    int d;
    longint m;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    sp = 1'b1;
    r  = 32'd0;
    if (an || bn)      r = QNAN;
    else if (ai && bi) r = (a[31] != b[31]) ? QNAN : a;
    else if (ai)       r = a;
    else if (bi)       r = b;
    else if (az && bz) r = {a[31] & b[31], 31'd0};
    else if (az)       r = b;
    else if (bz)       r = a;
    else               sp = 1'b0;
    if (longint'(b[30:0]) > longint'(a[30:0])) begin big = b; sml = a; end
    else begin big = a; sml = b; end
    sg = big[31];
    e  = big[30:23];
    d  = int'(big[30:23]) - int'(sml[30:23]);
    mg = 28'((longint'(8388608) + longint'(big[22:0])) * 8);
    m  = (longint'(8388608) + longint'(sml[22:0])) * 8;
    if (d > 27) ms = 28'd1;
    else ms = 28'((m >> d) | (((m % (longint'(1) << d)) != 0) ? 1 : 0));
  endfunction

  function automatic logic [31:0] gen_fp();
    logic [31:0] x;
    x[31] = 1'($urandom);
    x[22:0] = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin x[30:23] = 8'hFF; x[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
      1: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      2: begin x[30:23] = 8'h00; x[22:0] = 23'd0; end
      3: x[30:23] = 8'h00;
      default: x[30:23] = 8'($urandom_range(1, 254));
    endcase
    return x;
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int eb;
    a = gen_fp();
    b = gen_fp();
    if ($urandom_range(0, 1) == 1 && a[30:23] != 8'h00 && a[30:23] != 8'hFF) begin
      eb = int'(a[30:23]) - int'($urandom_range(0, 30));
      if (eb < 1) eb = 1;
      b[30:23] = 8'(eb);
    end
  endtask

  // One modelled cycle: check outputs mid-cycle, update the model, then advance past the edge.
  task automatic step();
    bit ev [2];
    bit el0, el1, sp, sg;
    int g;
    logic [31:0] a, b, r, v;
    logic [7:0] e;
    logic [27:0] mg, ms;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data0", rsp_data0, 0);
      check("rst_rsp_data1", rsp_data1, 0);
      check("rst_dp_valid", dp_valid, 0);
      check("rst_ops_done", ops_done, 0);
      check("rst_special_cnt", special_cnt, 0);
      m_has[0] = 0; m_has[1] = 0; m_ptr = 0; m_ops = 0; m_spc = 0;
    end else begin
      check("ops_done", ops_done, m_ops % (1 << CNT_W));
      check("special_cnt", special_cnt, m_spc % (1 << CNT_W));
      for (int i = 0; i < 2; i++) begin
        ev[i] = m_has[i] && (c >= m_due[i]);
        check($sformatf("rsp_valid%0d", i), rsp_valid[i], ev[i]);
        if (ev[i]) check($sformatf("rsp_data%0d", i), (i == 0) ? rsp_data0 : rsp_data1, m_val[i]);
      end
      el0 = req_valid[0] && !m_has[0];
      el1 = req_valid[1] && !m_has[1];
      g = -1;
      if (el0 && el1) g = m_ptr ? 1 : 0;
      else if (el0) g = 0;
      else if (el1) g = 1;
      check("req_ready", req_ready, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
      if (g >= 0) begin
        a = (g == 0) ? req_a0 : req_a1;
        b = (g == 0) ? req_b0 : req_b1;
        ref_pre(a, b, sp, r, sg, e, mg, ms);
        m_has[g] = 1;
        m_ptr = (g == 0);
        if (sp) begin
          check("dp_valid_special", dp_valid, 0);
          m_due[g] = c + 1;
          m_val[g] = r;
          m_spc++;
        end else begin
          check("dp_valid_issue", dp_valid, 1);
          check("dp_sign", dp_sign, sg);
          check("dp_exp", dp_exp, e);
          check("dp_mantis_great", dp_mantis_great, mg);
          check("dp_mantis_small", dp_mantis_small, ms);
          v = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : $urandom;
          res_at[c + LAT] = v;
          m_due[g] = c + LAT + 1;
          m_val[g] = v;
        end
      end else begin
        check("dp_valid_idle", dp_valid, 0);
      end
      for (int i = 0; i < 2; i++)
        if (ev[i] && rsp_ready[i]) begin m_has[i] = 0; m_ops++; end
    end
    @(posedge clk);
    #1;
    c++;
    if (res_at.exists(c)) begin dp_result = res_at[c]; res_at.delete(c); end
    else dp_result = $urandom;
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] a, b;
    int guard;
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00; dp_result = 32'd0; c = 0;
    req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000; req_a1 = 32'h4000_0000; req_b1 = 32'h3F80_0000;
    m_has[0] = 0; m_has[1] = 0; m_ptr = 0; m_ops = 0; m_spc = 0;
    #1;
    step(); step();

    // Contention right after reset: requester 0 then requester 1.
    rst_n = 1'b1; rsp_ready = 2'b11;
    step();
    req_a0 = 32'h4120_0000; req_b0 = 32'h3F00_0000;
    step();
    idle(8);

    // Normal add with bench back-end result 3.0.
    req_valid = 2'b01; req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000;
    step();
    idle(8);

    // Special case: NaN operand on requester 1.
    req_valid = 2'b10; req_a1 = 32'h7FC0_0000; req_b1 = 32'h3F80_0000;
    step();
    idle(4);

    // Backpressure on requester 0 while requester 1 keeps working.
    req_valid = 2'b01; rsp_ready = 2'b10; req_a0 = 32'h3F80_0000; req_b0 = 32'h3F00_0000;
    step();
    for (int i = 0; i < 16; i++) begin
      req_valid = 2'b11; rsp_ready = 2'b10;
      gen_pair(a, b); req_a1 = a; req_b1 = b;
      step();
    end
    idle(8);

    // Reset mid-flight; the late back-end result must be ignored.
    req_valid = 2'b01; req_a0 = 32'h4080_0000; req_b0 = 32'h3F80_0000;
    step();
    req_valid = 2'b00; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(6);

    // Counter wrap: 17 responses from reset with a 4-bit counter.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    guard = 0;
    while (m_ops < 17 && guard < 400) begin
      req_valid = (m_ops >= 16) ? 2'b01 : 2'($urandom);
      if (m_has[0] && m_has[1]) req_valid = 2'b00;
      rsp_ready = (m_ops >= 16) ? 2'b01 : 2'b11;
      gen_pair(a, b); req_a0 = a; req_b0 = b;
      gen_pair(a, b); req_a1 = a; req_b1 = b;
      step();
      guard++;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    #1;
    check("wrap_ops_done", ops_done, 1);
    idle(6);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom);
      rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      gen_pair(a, b); req_a0 = a; req_b0 = b;
      gen_pair(a, b); req_a1 = a; req_b1 = b;
      step();
    end
    rst_n = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
